// File: rtl/id_stage_pipe.sv
// Decode stage with EX/MEM forwarding and an integrated ID/EX register.
// Optional shift group enabled by defining ID_SHIFT_EN.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_valid_i,
    input  logic [DATA_W-1:0]   pc_i,
    input  logic [31:0]         inst_i,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [RADDR_W-1:0]  reg1_addr_o,
    output logic [RADDR_W-1:0]  reg2_addr_o,
    input  logic                ex_wreg_i,
    input  logic [RADDR_W-1:0]  ex_wd_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                mem_wreg_i,
    input  logic [RADDR_W-1:0]  mem_wd_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                ex_valid_o,
    output logic [DATA_W-1:0]   ex_pc_o,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic [ALUSEL_W-1:0] ex_alusel_o,
    output logic [DATA_W-1:0]   ex_reg1_o,
    output logic [DATA_W-1:0]   ex_reg2_o,
    output logic [RADDR_W-1:0]  ex_wd_o,
    output logic                ex_wreg_o,
    output logic [CNT_W-1:0]    inv_cnt_o
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    logic [ALUOP_W-1:0]  d_aluop;
    logic [ALUSEL_W-1:0] d_alusel;
    logic [RADDR_W-1:0]  d_wd;
    logic                d_wreg;
    logic                d_re1;
    logic                d_re2;
    logic                d_inv;
    logic [DATA_W-1:0]   d_imm1;
    logic [DATA_W-1:0]   d_imm2;

    always_comb begin
        d_aluop  = '0;
        d_alusel = '0;
        d_wd     = '0;
        d_wreg   = 1'b0;
        d_re1    = 1'b0;
        d_re2    = 1'b0;
        d_inv    = 1'b1;
        d_imm1   = '0;
        d_imm2   = '0;
        unique case (1'b1)
            (op == 6'h0D), (op == 6'h0C), (op == 6'h0E): begin
                d_aluop  = (op == 6'h0D) ? ALUOP_W'(8'h25) :
                           (op == 6'h0C) ? ALUOP_W'(8'h24) :
                                           ALUOP_W'(8'h26);
                d_alusel = ALUSEL_W'(3'b001);
                d_re1    = 1'b1;
                d_imm2   = DATA_W'(imm16);
                d_wd     = RADDR_W'(rt);
                d_wreg   = 1'b1;
                d_inv    = 1'b0;
            end
            (op == 6'h0F): begin
                d_aluop  = ALUOP_W'(8'h25);
                d_alusel = ALUSEL_W'(3'b001);
                d_imm2   = DATA_W'({imm16, 16'h0000});
                d_wd     = RADDR_W'(rt);
                d_wreg   = 1'b1;
                d_inv    = 1'b0;
            end
            (op == 6'h00) && (sa == 5'd0) &&
            (funct >= 6'h24) && (funct <= 6'h27): begin
                d_aluop  = ALUOP_W'(funct);
                d_alusel = ALUSEL_W'(3'b001);
                d_re1    = 1'b1;
                d_re2    = 1'b1;
                d_wd     = RADDR_W'(rd);
                d_wreg   = 1'b1;
                d_inv    = 1'b0;
            end
`ifdef ID_SHIFT_EN
            (op == 6'h00) && (rs == 5'd0) &&
            ((funct == 6'h00) || (funct == 6'h02) ||
             (funct == 6'h03)): begin
                d_aluop  = (funct == 6'h00) ? ALUOP_W'(8'h7C) :
                                              ALUOP_W'(funct);
                d_alusel = ALUSEL_W'(3'b010);
                d_imm1   = DATA_W'(sa);
                d_re2    = 1'b1;
                d_wd     = RADDR_W'(rd);
                d_wreg   = 1'b1;
                d_inv    = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    assign reg1_addr_o = RADDR_W'(rs);
    assign reg2_addr_o = RADDR_W'(rt);
    assign reg1_read_o = d_re1 & ~rst;
    assign reg2_read_o = d_re2 & ~rst;

    // EX result is newer than MEM, so it wins on a double match.
    function automatic logic [DATA_W-1:0] fwd(
        input logic               re,
        input logic [RADDR_W-1:0] addr,
        input logic [DATA_W-1:0]  imm,
        input logic [DATA_W-1:0]  rf
    );
        if (!re)
            return imm;
        else if (addr == '0)
            return '0;
        else if (ex_wreg_i && ex_wd_i == addr)
            return ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == addr)
            return mem_wdata_i;
        else
            return rf;
    endfunction

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    assign op1 = fwd(d_re1, reg1_addr_o, d_imm1, reg1_data_i);
    assign op2 = fwd(d_re2, reg2_addr_o, d_imm2, reg2_data_i);

    logic load;
    assign load = ~flush_i & ~stall_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i || (load && !inst_valid_i)) begin
            ex_valid_o  <= 1'b0;
            ex_pc_o     <= '0;
            ex_aluop_o  <= '0;
            ex_alusel_o <= '0;
            ex_reg1_o   <= '0;
            ex_reg2_o   <= '0;
            ex_wd_o     <= '0;
            ex_wreg_o   <= 1'b0;
        end else if (load) begin
            ex_valid_o  <= 1'b1;
            ex_pc_o     <= pc_i;
            ex_aluop_o  <= d_aluop;
            ex_alusel_o <= d_alusel;
            ex_reg1_o   <= op1;
            ex_reg2_o   <= op2;
            ex_wd_o     <= d_wd;
            ex_wreg_o   <= d_wreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            inv_cnt_o <= '0;
        else if (load && inst_valid_i && d_inv && !(&inv_cnt_o))
            inv_cnt_o <= inv_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, stall/flush,
// invalid counting and reset.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] reg1_data_i;
    logic [31:0] reg2_data_i;
    logic        reg1_read_o;
    logic        reg2_read_o;
    logic [4:0]  reg1_addr_o;
    logic [4:0]  reg2_addr_o;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic        stall_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [31:0] ex_reg1_o;
    logic [31:0] ex_reg2_o;
    logic [4:0]  ex_wd_o;
    logic        ex_wreg_o;
    logic [15:0] inv_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid_i (inst_valid_i),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .reg1_data_i  (reg1_data_i),
        .reg2_data_i  (reg2_data_i),
        .reg1_read_o  (reg1_read_o),
        .reg2_read_o  (reg2_read_o),
        .reg1_addr_o  (reg1_addr_o),
        .reg2_addr_o  (reg2_addr_o),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .ex_valid_o   (ex_valid_o),
        .ex_pc_o      (ex_pc_o),
        .ex_aluop_o   (ex_aluop_o),
        .ex_alusel_o  (ex_alusel_o),
        .ex_reg1_o    (ex_reg1_o),
        .ex_reg2_o    (ex_reg2_o),
        .ex_wd_o      (ex_wd_o),
        .ex_wreg_o    (ex_wreg_o),
        .inv_cnt_o    (inv_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
            $error("check %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string tag, input logic v,
                          input logic [7:0] aop, input logic [2:0] asel,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wr);
        chk({tag, ".valid"}, 64'(ex_valid_o), 64'(v));
        chk({tag, ".aluop"}, 64'(ex_aluop_o), 64'(aop));
        chk({tag, ".alusel"}, 64'(ex_alusel_o), 64'(asel));
        chk({tag, ".reg1"}, 64'(ex_reg1_o), 64'(r1));
        chk({tag, ".reg2"}, 64'(ex_reg2_o), 64'(r2));
        chk({tag, ".wd"}, 64'(ex_wd_o), 64'(wd));
        chk({tag, ".wreg"}, 64'(ex_wreg_o), 64'(wr));
    endtask

    initial begin
        rst = 1'b1;
        inst_valid_i = 1'b0;
        pc_i = '0;
        inst_i = 32'h3401_1100;
        reg1_data_i = '0;
        reg2_data_i = '0;
        ex_wreg_i = 1'b0;
        ex_wd_i = '0;
        ex_wdata_i = '0;
        mem_wreg_i = 1'b0;
        mem_wd_i = '0;
        mem_wdata_i = '0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        tick();
        chk_ex("reset", 0, 8'h00, 3'd0, 0, 0, 0, 0);
        chk("reset.pc", 64'(ex_pc_o), 64'h0);
        chk("reset.cnt", 64'(inv_cnt_o), 64'h0);
        chk("rst.re1", 64'(reg1_read_o), 64'h0);
        chk("rst.addr1", 64'(reg1_addr_o), 64'h0);
        chk("rst.addr2", 64'(reg2_addr_o), 64'h1);

        // ORI $1,$0,0x1100
        rst = 1'b0;
        inst_valid_i = 1'b1;
        pc_i = 32'h0000_0100;
        #1;
        chk("ori.re1", 64'(reg1_read_o), 64'h1);
        chk("ori.re2", 64'(reg2_read_o), 64'h0);
        tick();
        chk_ex("ori", 1, 8'h25, 3'd1, 32'h0, 32'h0000_1100, 5'd1, 1);
        chk("ori.pc", 64'(ex_pc_o), 64'h100);

        // OR $3,$1,$2: EX forwards $1, MEM forwards $2
        inst_i = 32'h0022_1825;
        pc_i = 32'h0000_0104;
        ex_wreg_i = 1'b1;
        ex_wd_i = 5'd1;
        ex_wdata_i = 32'hAAAA_0000;
        mem_wreg_i = 1'b1;
        mem_wd_i = 5'd2;
        mem_wdata_i = 32'h0000_000F;
        reg1_data_i = 32'h5;
        reg2_data_i = 32'h99;
        #1;
        chk("or.re2", 64'(reg2_read_o), 64'h1);
        tick();
        chk_ex("or_fwd", 1, 8'h25, 3'd1, 32'hAAAA_0000, 32'hF, 5'd3, 1);

        // Same OR: MEM now targets $1, EX elsewhere; $2 from file
        ex_wd_i = 5'd9;
        mem_wd_i = 5'd1;
        mem_wdata_i = 32'h5;
        reg2_data_i = 32'h77;
        tick();
        chk("or_mem.reg1", 64'(ex_reg1_o), 64'h5);
        chk("or_mem.reg2", 64'(ex_reg2_o), 64'h77);

        // EX and MEM both match $1: EX wins
        mem_wdata_i = 32'h1111_2222;
        ex_wd_i = 5'd1;
        tick();
        chk("or_pri.reg1", 64'(ex_reg1_o), 64'hAAAA_0000);

        // XORI $2,$1,0xFFFF from register file, then stall 3 cycles
        ex_wreg_i = 1'b0;
        mem_wreg_i = 1'b0;
        reg1_data_i = 32'h1234_5678;
        inst_i = 32'h3822_FFFF;
        pc_i = 32'h0000_0200;
        tick();
        chk_ex("xori", 1, 8'h26, 3'd1, 32'h1234_5678, 32'hFFFF, 5'd2, 1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_i = (i == 1) ? 32'hFC00_0000 : 32'h3000_00AB + 32'(i);
            pc_i = 32'h300 + 32'(i);
            tick();
            chk_ex("stall", 1, 8'h26, 3'd1, 32'h1234_5678, 32'hFFFF,
                   5'd2, 1);
            chk("stall.pc", 64'(ex_pc_o), 64'h200);
        end
        chk("stall.cnt", 64'(inv_cnt_o), 64'h0);
        flush_i = 1'b1;
        tick();
        chk_ex("stall_flush", 0, 8'h00, 3'd0, 0, 0, 0, 0);
        chk("flush.pc", 64'(ex_pc_o), 64'h0);
        stall_i = 1'b0;
        flush_i = 1'b0;

        // LUI $5,0x1234 while EX writes $0
        inst_i = 32'h3C05_1234;
        pc_i = 32'h0000_0400;
        ex_wreg_i = 1'b1;
        ex_wd_i = 5'd0;
        ex_wdata_i = 32'h0000_FFFF;
        #1;
        chk("lui.re1", 64'(reg1_read_o), 64'h0);
        tick();
        chk_ex("lui", 1, 8'h25, 3'd1, 32'h0, 32'h1234_0000, 5'd5, 1);

        // OR $6,$0,$0: forwarded $0 must read 0
        inst_i = 32'h0000_3025;
        reg1_data_i = 32'hDEAD;
        reg2_data_i = 32'hBEEF;
        tick();
        chk_ex("or_r0", 1, 8'h25, 3'd1, 32'h0, 32'h0, 5'd6, 1);
        ex_wreg_i = 1'b0;

        // NOR $7,$1,$2 from register file
        inst_i = 32'h0022_3827;
        reg1_data_i = 32'h10;
        reg2_data_i = 32'h20;
        tick();
        chk_ex("nor", 1, 8'h27, 3'd1, 32'h10, 32'h20, 5'd7, 1);

        // Opcode 0x3F three times, then once without inst_valid_i
        inst_i = 32'hFC00_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ex("inv", 1, 8'h00, 3'd0, 0, 0, 0, 0);
        end
        chk("inv.cnt3", 64'(inv_cnt_o), 64'h3);
        inst_valid_i = 1'b0;
        tick();
        chk("inv_nv.valid", 64'(ex_valid_o), 64'h0);
        chk("inv_nv.cnt", 64'(inv_cnt_o), 64'h3);
        inst_valid_i = 1'b1;

        // Invalid instruction under flush does not count
        flush_i = 1'b1;
        tick();
        chk("inv_fl.cnt", 64'(inv_cnt_o), 64'h3);
        flush_i = 1'b0;

        // SRA $4,$2,5
        inst_i = 32'h0002_2143;
        reg2_data_i = 32'h8000_0040;
        tick();
`ifdef ID_SHIFT_EN
        chk_ex("sra", 1, 8'h03, 3'd2, 32'h5, 32'h8000_0040, 5'd4, 1);
        chk("sra.cnt", 64'(inv_cnt_o), 64'h3);
        inst_i = 32'h0;
        tick();
        chk_ex("nop", 1, 8'h7C, 3'd2, 0, 0, 0, 1);
        chk("nop.cnt", 64'(inv_cnt_o), 64'h3);
`else
        chk_ex("sra_inv", 1, 8'h00, 3'd0, 0, 0, 0, 0);
        chk("sra.cnt", 64'(inv_cnt_o), 64'h4);
        inst_i = 32'h0;
        tick();
        chk("zero.wreg", 64'(ex_wreg_o), 64'h0);
        chk("zero.cnt", 64'(inv_cnt_o), 64'h5);
`endif

        // Reset during stall+flush clears everything
        inst_i = 32'h3401_1100;
        stall_i = 1'b1;
        flush_i = 1'b1;
        rst = 1'b1;
        tick();
        chk_ex("rst2", 0, 8'h00, 3'd0, 0, 0, 0, 0);
        chk("rst2.cnt", 64'(inv_cnt_o), 64'h0);
        chk("rst2.re1", 64'(reg1_read_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised second-generation decode stage for the openMips integer pipeline. It decodes the I-type and R-type logic group, plus an optional shift group, and reads the register file through the existing `reg1/reg2` address/read-enable ports. It resolves RAW hazards by forwarding from the EX and MEM stages and registers all results into an internal ID/EX pipeline register with stall, flush and valid tracking. It sits between the IF/ID register and the EX stage and replaces the combinational decoder plus the separate ID/EX register.

## Interface
Parameters:
- `DATA_W`, 32, register/operand width (≥ 32)
- `RADDR_W`, 5, register address width
- `ALUOP_W`, 8, ALU opcode width
- `ALUSEL_W`, 3, ALU result-select width
- `CNT_W`, 16, invalid-instruction counter width

Ports:
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `inst_valid_i` in 1: `inst_i` / `pc_i` carry a real instruction
- `pc_i` in DATA_W: instruction address
- `inst_i` in 32: instruction word
- `reg1_data_i` / `reg2_data_i` in DATA_W: register file read data
- `reg1_read_o` / `reg2_read_o` out 1: register file read enables (combinational)
- `reg1_addr_o` / `reg2_addr_o` out RADDR_W: read addresses rs / rt (combinational)
- `ex_wreg_i`, `ex_wd_i`, `ex_wdata_i` in 1/RADDR_W/DATA_W: EX-stage write-back
- `mem_wreg_i`, `mem_wd_i`, `mem_wdata_i` in 1/RADDR_W/DATA_W: MEM-stage write-back
- `stall_i` in 1: hold the ID/EX register
- `flush_i` in 1: load a bubble into the ID/EX register
- `ex_valid_o` out 1: registered, the EX payload is live
- `ex_pc_o` out DATA_W: registered PC
- `ex_aluop_o` out ALUOP_W, `ex_alusel_o` out ALUSEL_W: registered ALU opcode and result select
- `ex_reg1_o`, `ex_reg2_o` out DATA_W: registered operands
- `ex_wd_o` out RADDR_W, `ex_wreg_o` out 1: registered destination and write enable
- `inv_cnt_o` out CNT_W: saturating count of invalid instructions

## Operation
- Decode is combinational from `inst_i`; the read address outputs are always rs=`inst_i[25:21]` and rt=`inst_i[20:16]`.
- ORI 0x0D / ANDI 0x0C / XORI 0x0E:
  - aluop OR 0x25 / AND 0x24 / XOR 0x26, alusel LOGIC 3'b001
  - reg1 = rs (read), reg2 = zero-extended imm16, wd = rt
- LUI 0x0F: aluop OR, alusel LOGIC, reg1 = 0 (no read), reg2 = {imm16, 16'h0}, wd = rt.
- SPECIAL 0x00 with `inst_i[10:6]`==0, funct OR 0x25 / AND 0x24 / XOR 0x26 / NOR 0x27: reg1 = rs, reg2 = rt (both read), wd = rd=`inst_i[15:11]`.
- Unmatched opcode or funct:
  - aluop 0x00, alusel 3'b000, wreg 0, no reads
  - the instruction is invalid; it still propagates with `ex_valid_o`=1
- An operand slot that is not read takes its immediate/shamt value; otherwise 0. Immediates are zero-extended to DATA_W.
- Forwarding applies per read operand, with priority: EX match > MEM match > `regN_data_i`.
  - A match requires `*_wreg_i`=1, `*_wd_i`==read address, and read address ≠ 0.
  - Address 0 always yields 0.
- Register update priority: `rst` > `flush_i` > `stall_i` > load.
  - Reset and flush load a bubble: all ex_* outputs 0.
  - Stall holds every ex_* output.
  - Load captures the decode result; `ex_valid_o` = `inst_valid_i`. If `inst_valid_i`=0, a bubble is loaded.
- `inv_cnt_o` increments on a load cycle with `inst_valid_i`=1 and an invalid decode. It saturates at all-ones. It is not affected by flush or stall.

## Timing
- Reset: every ex_* output and `inv_cnt_o` is 0 on the cycle after `rst` is sampled high. Reset mid-stall or mid-flush wins.
- Latency: one cycle from `inst_i` to ex_* outputs.
- Forwarding sources are sampled in the same cycle as decode. A result produced by EX in cycle N is consumed by the instruction decoding in cycle N.
- Flush and stall asserted together: flush wins.
- Read enables and addresses are valid combinationally during `rst`. Read enables are 0 when `rst`=1.

## Configuration
- `ID_SHIFT_EN`, when defined, adds SPECIAL funct SLL 0x00 / SRL 0x02 / SRA 0x03 with rs field 0:
  - aluop 0x7C / 0x02 / 0x03, alusel SHIFT 3'b010
  - reg1 = zero-extended sa=`inst_i[10:6]` (no read), reg2 = rt (read), wd = rd
  - `inst_i`=0 decodes as SLL $0,$0,0, a valid NOP
- Without `ID_SHIFT_EN`, these encodings are invalid, count in `inv_cnt_o`, and `inst_i`=0 is invalid.

## Test plan
- ORI $1,$0,0x1100 (0x34011100), no hazards → next cycle: aluop 0x25, alusel 1, reg1 0, reg2 0x00001100, wd 1, wreg 1, valid 1.
- OR $3,$1,$2 with EX writing $1=0xAAAA0000 and MEM writing $1=0x5 and $2=0x0F → reg1 0xAAAA0000, reg2 0x0000000F, wd 3.
- `stall_i`=1 for 3 cycles while `inst_i` changes → ex_* outputs hold. `stall_i`+`flush_i` together → outputs 0.
- LUI $5,0x1234 then EX write to $0 of 0xFFFF with a read of $0 → reg2 0x12340000; forwarded $0 operand reads 0.
- Opcode 0x3F repeated 3 times with `inst_valid_i`=1, then once with `inst_valid_i`=0 → `inv_cnt_o`=3, wreg 0. `rst` → counter 0.
- With `ID_SHIFT_EN`: SRA $4,$2,5 (0x00022143) → aluop 0x03, alusel 2, reg1 5, wd 4. Without it: invalid, counter +1.
